framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/led_panel_pkg.sv | 23 ++
 rtl/framebuffer_writer_if.sv | 13 +
 rtl/framebuffer_writer.sv | 165 ++++++++++++++++
 tb/tb_framebuffer_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// Shared LED panel definitions: geometry, RAM address width, pixel layout
// and the frame writer state encoding. The panel driver imports this too.
package led_panel_pkg;

  localparam int PANEL_COLS = 64;
  localparam int PANEL_ROWS = 32;
  localparam int HALF_ROWS  = PANEL_ROWS / 2;
  localparam int ADDR_W     = 11;
  localparam int PIX_W      = 24;

  // Pixel field offsets inside the 24-bit pixel word.
  localparam int RED_LSB    = 0;
  localparam int GREEN_LSB  = 8;
  localparam int BLUE_LSB   = 16;
  localparam int FIELD_W    = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream into the frame writer: valid/ready handshake with a
// start-of-frame marker on the first pixel.
interface framebuffer_writer_if #(
  parameter int DATA_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;

  modport master (output in_valid, output in_data, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_data, input in_sof, output in_ready);
endinterface

// File: rtl/framebuffer_writer.sv
// Frame writer: scans an incoming pixel stream into the back half of a
// double-buffered panel RAM (split into hi/lo row halves), then requests a
// buffer swap and waits for the panel driver to take it.
module framebuffer_writer
  import led_panel_pkg::*;
#(
  parameter int COLS   = PANEL_COLS,
  parameter int ROWS   = PANEL_ROWS,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  framebuffer_writer_if.slave pix,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en_hi,
  output logic              wr_en_lo,
  output logic              selected_buffer,
  input  logic              actual_buffer,
  output logic              frame_done,
  output logic              sof_error,
  output logic [15:0]       drop_count
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_HALF = ROW_W'(ROWS / 2);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  fb_state_e        state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             sel_q, sel_d;
  logic             sof_err_q, sof_err_d;
  logic             done_q, done_d;
  logic [15:0]      drop_q, drop_d;

  logic             vld_p0;
  logic [ROW_W-1:0] row_p0;
  logic [COL_W-1:0] col_p0;

  logic              vld_p1;
  logic              lo_half_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  // Ready is decoded from state only, so it never depends on in_valid.
  assign pix.in_ready = (state_q != SWAP_WAIT);

  // Next-state, write position and counter/flag updates.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    sel_d     = sel_q;
    sof_err_d = sof_err_q;
    done_d    = 1'b0;
    drop_d    = drop_q;
    vld_p0    = 1'b0;
    row_p0    = row_q;
    col_p0    = col_q;

    case (state_q)
      IDLE: begin
        if (pix.in_valid) begin
          if (pix.in_sof) begin
            vld_p0 = 1'b1;
            row_p0 = '0;
            col_p0 = '0;
          end else begin
            drop_d = sat_inc16(drop_q);
          end
        end
      end
      WRITE: begin
        if (pix.in_valid) begin
          vld_p0 = 1'b1;
          // An SOF mid-frame restarts the scan at the origin of the same buffer.
          if (pix.in_sof) begin
            row_p0 = '0;
            col_p0 = '0;
            if ((row_q != '0) || (col_q != '0)) sof_err_d = 1'b1;
          end
        end
      end
      SWAP_WAIT: begin
        if (actual_buffer == sel_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (vld_p0) begin
      if (col_p0 == COL_LAST) begin
        col_d = '0;
        if (row_p0 == ROW_LAST) begin
          row_d   = '0;
          sel_d   = ~sel_q;
          state_d = SWAP_WAIT;
        end else begin
          row_d   = row_p0 + 1'b1;
          state_d = WRITE;
        end
      end else begin
        col_d   = col_p0 + 1'b1;
        row_d   = row_p0;
        state_d = WRITE;
      end
    end
  end

  // Control state, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      sel_q     <= 1'b0;
      sof_err_q <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      sel_q     <= sel_d;
      sof_err_q <= sof_err_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  // ---- stage p0 -> p1: registered RAM write port ----
  // The back buffer is sampled with the beat, before any swap toggles sel_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      lo_half_p1 <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1     <= vld_p0;
      lo_half_p1 <= (row_p0 >= ROW_HALF);
      wr_addr_p1 <= {~sel_q, row_p0[ROW_W-2:0], col_p0};
      wr_data_p1 <= pix.in_data;
    end
  end

  assign wr_addr         = wr_addr_p1;
  assign wr_data         = wr_data_p1;
  assign wr_en_hi        = vld_p1 & ~lo_half_p1;
  assign wr_en_lo        = vld_p1 &  lo_half_p1;
  assign selected_buffer = sel_q;
  assign frame_done      = done_q;
  assign sof_error       = sof_err_q;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: idle drops, full frames with swap
// handshake, sparse stream with early SOF, and reset mid-frame.
module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        actual_buffer;
  logic [10:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_en_hi;
  logic        wr_en_lo;
  logic        selected_buffer;
  logic        frame_done;
  logic        sof_error;
  logic [15:0] drop_count;

  framebuffer_writer_if #(.DATA_W(24)) pix_if ();

  framebuffer_writer #(.COLS(64), .ROWS(32), .DATA_W(24)) dut (
    .clk             (clk),
    .rst             (rst),
    .pix             (pix_if),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_en_hi        (wr_en_hi),
    .wr_en_lo        (wr_en_lo),
    .selected_buffer (selected_buffer),
    .actual_buffer   (actual_buffer),
    .frame_done      (frame_done),
    .sof_error       (sof_error),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Write log, sampled on the falling edge.
  logic [10:0] log_addr[$];
  logic [23:0] log_data[$];
  bit          log_lo[$];
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (wr_en_hi || wr_en_lo) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_lo.push_back(wr_en_lo);
    end
    if (wr_en_hi && wr_en_lo) both_cnt++;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_lo.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input logic sof);
    int w;
    w = 0;
    pix_if.in_valid = 1'b1;
    pix_if.in_data  = d;
    pix_if.in_sof   = sof;
    while (pix_if.in_ready !== 1'b1 && w < 1000) begin
      tick();
      w++;
    end
    if (w >= 1000) check("send_ready", 32'(pix_if.in_ready), 32'd1);
    tick();
    pix_if.in_valid = 1'b0;
    pix_if.in_sof   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (frame_done !== 1'b1 && w < 2000) begin
      tick();
      w++;
    end
    check(tag, 32'(frame_done), 32'd1);
  endtask

  // Full-frame scoreboard: beat n lands at {back, n[9:0]} with data n, lo half from n>=1024.
  task automatic check_frame(input string tag, input logic back);
    int errs;
    errs = 0;
    for (int i = 0; i < 2048; i++) begin
      if (log_addr[i] !== {back, i[9:0]} || log_data[i] !== i[23:0] || log_lo[i] !== (i >= 1024))
        errs++;
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    int ready_hi;
    int done_seen;
    int nhi;
    int nlo;
    int hi_buf;
    int gap_strobe;

    rst             = 1'b1;
    actual_buffer   = 1'b0;
    pix_if.in_valid = 1'b0;
    pix_if.in_sof   = 1'b0;
    pix_if.in_data  = '0;
    do_reset();

    // Reset state
    check("rst_sel",      32'(selected_buffer), 32'd0);
    check("rst_en_hi",    32'(wr_en_hi),        32'd0);
    check("rst_en_lo",    32'(wr_en_lo),        32'd0);
    check("rst_addr",     32'(wr_addr),         32'd0);
    check("rst_data",     32'(wr_data),         32'd0);
    check("rst_done",     32'(frame_done),      32'd0);
    check("rst_sof_err",  32'(sof_error),       32'd0);
    check("rst_drop",     32'(drop_count),      32'd0);
    check("rst_ready",    32'(pix_if.in_ready), 32'd1);

    // Idle drops: no SOF, nothing written
    clear_log();
    for (int i = 0; i < 5; i++) send(24'hA0 + 24'(i), 1'b0);
    tick();
    check("idle_drop_cnt", 32'(drop_count),    32'd5);
    check("idle_no_write", 32'(log_addr.size()), 32'd0);

    // Frame 1: pixel n = n, back buffer 1
    clear_log();
    for (int n = 0; n < 2048; n++) send(24'(n), n == 0);
    tick();
    nhi = 0;
    nlo = 0;
    foreach (log_lo[i]) begin
      if (log_lo[i]) nlo++;
      else nhi++;
    end
    check("f1_size",        32'(log_addr.size()),  32'd2048);
    check("f1_hi_cnt",      32'(nhi),              32'd1024);
    check("f1_lo_cnt",      32'(nlo),              32'd1024);
    check("f1_b1000_addr",  32'(log_addr[1000][9:0]), 32'h3E8);
    check("f1_b1000_buf",   32'(log_addr[1000][10]),  32'd1);
    check("f1_b1000_lo",    32'(log_lo[1000]),     32'd0);
    check("f1_b1000_data",  32'(log_data[1000]),   32'd1000);
    check("f1_b1024_addr",  32'(log_addr[1024][9:0]), 32'h000);
    check("f1_b1024_lo",    32'(log_lo[1024]),     32'd1);
    check_frame("f1_seq", 1'b1);
    check("f1_both_en",     32'(both_cnt),         32'd0);
    check("f1_sel",         32'(selected_buffer),  32'd1);
    check("f1_ready_low",   32'(pix_if.in_ready),  32'd0);

    // Swap stall: driver still on buffer 0, inputs must be ignored
    pix_if.in_valid = 1'b1;
    pix_if.in_sof   = 1'b1;
    pix_if.in_data  = 24'hFFFFFF;
    ready_hi  = 0;
    done_seen = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (pix_if.in_ready) ready_hi++;
      if (frame_done) done_seen++;
    end
    pix_if.in_valid = 1'b0;
    pix_if.in_sof   = 1'b0;
    check("stall_ready",    32'(ready_hi),         32'd0);
    check("stall_no_done",  32'(done_seen),        32'd0);
    check("stall_no_write", 32'(log_addr.size()),  32'd2048);
    check("stall_drop",     32'(drop_count),       32'd5);
    check("stall_sof_err",  32'(sof_error),        32'd0);
    actual_buffer = 1'b1;
    tick();
    check("swap_done",      32'(frame_done),       32'd1);
    check("swap_ready",     32'(pix_if.in_ready),  32'd1);
    tick();
    check("swap_done_pulse", 32'(frame_done),      32'd0);

    // Frame 2: back buffer 0, selection returns to 0
    clear_log();
    for (int n = 0; n < 2048; n++) send(24'(n), n == 0);
    tick();
    hi_buf = 0;
    foreach (log_addr[i]) if (log_addr[i][10]) hi_buf++;
    check("f2_size",     32'(log_addr.size()), 32'd2048);
    check("f2_buf1_wr",  32'(hi_buf),          32'd0);
    check_frame("f2_seq", 1'b0);
    check("f2_sel",      32'(selected_buffer), 32'd0);
    actual_buffer = 1'b0;
    wait_done("f2_done");

    // Sparse stream, 3-cycle gaps, early SOF at beat 100
    clear_log();
    gap_strobe = 0;
    for (int b = 0; b < 102; b++) begin
      if (b == 100) check("sparse_pre_err", 32'(sof_error), 32'd0);
      send(24'h100000 + 24'(b), (b == 0) || (b == 100));
      for (int g = 0; g < 3; g++) begin
        tick();
        if (wr_en_hi || wr_en_lo) gap_strobe++;
      end
    end
    check("sparse_sof_err",  32'(sof_error),        32'd1);
    check("sparse_size",     32'(log_addr.size()),  32'd102);
    check("sparse_gap_wr",   32'(gap_strobe),       32'd0);
    check("sparse_b99_addr", 32'(log_addr[99]),     32'h463);
    check("sparse_b100_addr", 32'(log_addr[100]),   32'h400);
    check("sparse_b100_data", 32'(log_data[100]),   32'h100064);
    check("sparse_b101_addr", 32'(log_addr[101]),   32'h401);

    // Reset at beat 1500 abandons the frame
    do_reset();
    check("pre_sof_err_clr", 32'(sof_error), 32'd0);
    clear_log();
    for (int n = 0; n < 1500; n++) send(24'(n), n == 0);
    rst = 1'b1;
    tick();
    check("mid_en_hi",   32'(wr_en_hi),        32'd0);
    check("mid_en_lo",   32'(wr_en_lo),        32'd0);
    check("mid_addr",    32'(wr_addr),         32'd0);
    check("mid_data",    32'(wr_data),         32'd0);
    check("mid_sel",     32'(selected_buffer), 32'd0);
    check("mid_done",    32'(frame_done),      32'd0);
    check("mid_drop",    32'(drop_count),      32'd0);
    check("mid_ready",   32'(pix_if.in_ready), 32'd1);
    check("mid_size",    32'(log_addr.size()), 32'd1500);
    rst = 1'b0;
    clear_log();
    send(24'h123456, 1'b1);
    tick();
    check("post_rst_size", 32'(log_addr.size()), 32'd1);
    check("post_rst_addr", 32'(log_addr[0]),     32'h400);
    check("post_rst_data", 32'(log_data[0]),     32'h123456);
    check("post_rst_lo",   32'(log_lo[0]),       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
